hazard_idexe_stage: RTL and testbench
=====================================

# hazard_idexe_stage

Load-use hazard detection and the ID/EX pipeline register for the 5-stage RISC-V core. Sits between decode and execute: it captures decoded operands and control each cycle, and drives the IF/PC stall and flush signals. It inserts a bubble on load-use hazards and on taken branches. Its registered rs1/rs2/rd/ctrl outputs are the EXE-stage fields consumed by the forwarding unit and the ALU operand muxes.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- hold_i  in  1  global freeze (memory wait); holds every stage
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  DATA_W each  decoded values
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW each  register indices
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  instruction actually reads rs1/rs2
- id_ctrl_i  in  8  {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, alu_op[1:0]}
- exe_branch_taken_i  in  1  branch/jump resolved taken in EX this cycle
- pc_write_o  out  1  PC may update
- ifid_write_o  out  1  IF/ID register may load
- ifid_flush_o  out  1  IF/ID register loads a bubble
- exe_valid_o, exe_pc_o, exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_ctrl_o  out  (matching widths)  registered ID/EX contents
- stall_cnt_o, flush_cnt_o  out  32 each  saturating event counters

## Operation
- Load-use hazard (comb) = id_valid_i & exe_valid_o & exe_ctrl_o.mem_read & exe_rd_o≠0 & ((id_uses_rs1_i & id_rs1_i==exe_rd_o) | (id_uses_rs2_i & id_rs2_i==exe_rd_o)).
- Priority, evaluated each cycle:
  1. hold_i: ID/EX keeps its contents. pc_write_o=0, ifid_write_o=0, ifid_flush_o=0. No counter updates.
  2. exe_branch_taken_i: ID/EX loads a bubble. pc_write_o=1, ifid_write_o=1, ifid_flush_o=1. flush_cnt_o increments. Any hazard is ignored because the ID instruction is killed.
  3. Hazard: ID/EX loads a bubble. pc_write_o=0, ifid_write_o=0, ifid_flush_o=0. stall_cnt_o increments.
  4. Otherwise: ID/EX loads the id_* inputs with exe_valid_o=id_valid_i. pc_write_o=1, ifid_write_o=1, ifid_flush_o=0.
- Bubble: valid=0, ctrl=8'h00, rs1/rs2/rd=0, data/imm/pc=0. The forwarding unit and the memory stage therefore see no write and no access.
- When id_valid_i=0, the id_* contents load unchanged, but ctrl is forced to 0.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- A load-use stall lasts exactly one cycle. After the bubble, exe_ctrl_o.mem_read=0, so the hazard clears.

## Timing
- ID/EX update: one cycle; the inputs sampled at edge N appear on exe_* after edge N.
- pc_write_o, ifid_write_o and ifid_flush_o are combinational from the current inputs and the ID/EX state. They have zero-cycle latency.
- Reset: asserting rst_i low clears all exe_* outputs and both counters to 0 immediately, regardless of clk_i. Comb outputs then read pc_write_o=1, ifid_write_o=1, ifid_flush_o=0 (unless hold_i or exe_branch_taken_i is set).
- Reset released mid-stall: the pipeline restarts with empty ID/EX; no stale hazard is retained.
- Simultaneous hold_i and exe_branch_taken_i: hold wins. The branch stays in EX and flushes on the first non-held cycle.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W=8
  - bit-index constants CTRL_REG_WRITE=7 … CTRL_ALU_OP_LSB=0
  - CTRL_BUBBLE=8'h00
- Sub-module hazard_detect (purely combinational load-use compare) is instantiated once. The register, priority logic and counters live in the top module.

## Test plan
- lw x5 in EX, add x6,x5,x7 in ID -> one cycle with pc_write_o=0, ifid_write_o=0; next cycle exe_ctrl_o=0, exe_valid_o=0; add enters EX on the following edge; stall_cnt_o=1.
- lw x0 in EX, ID reads x0 -> no stall; lw x5 in EX, ID is lui x5 (id_uses_rs1_i=0, id_uses_rs2_i=0) -> no stall.
- exe_branch_taken_i=1 together with a load-use hazard -> ifid_flush_o=1, pc_write_o=1, bubble enters EX; flush_cnt_o=1, stall_cnt_o unchanged.
- hold_i=1 for 3 cycles with add x1 in ID/EX -> exe_* unchanged for all 3 cycles, pc_write_o=0, counters unchanged.
- Preload stall_cnt_o to 32'hFFFF_FFFE via forced hazards, then two more hazards -> counter saturates at 32'hFFFF_FFFF.
- Assert rst_i=0 between clock edges during a stall -> exe_valid_o=0, exe_ctrl_o=0, counters=0 before the next edge; pc_write_o=1.

Source files
------------

// File: rtl/hazard_idexe_stage_pkg.sv
// Shared pipeline definitions: control-word layout, the bubble encoding and the
// per-cycle action of the ID/EX stage.
package pipe_pkg;

    localparam int unsigned CTRL_W          = 8;
    localparam int unsigned CTRL_REG_WRITE  = 7;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_MEM_READ   = 5;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_BRANCH     = 3;
    localparam int unsigned CTRL_ALU_SRC    = 2;
    localparam int unsigned CTRL_ALU_OP_MSB = 1;
    localparam int unsigned CTRL_ALU_OP_LSB = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

    typedef enum logic [1:0] {
        ACT_PASS,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_STALL
    } action_e;

endpackage

// File: rtl/hazard_idexe_stage_if.sv
// Decode-to-execute bundle: ID-stage fields in, EXE-stage fields and
// IF/PC control out.
interface hazard_idexe_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    import pipe_pkg::*;

    logic                hold_i;
    logic                id_valid_i;
    logic [DATA_W-1:0]   id_pc_i;
    logic [DATA_W-1:0]   id_rs1_data_i;
    logic [DATA_W-1:0]   id_rs2_data_i;
    logic [DATA_W-1:0]   id_imm_i;
    logic [REG_AW-1:0]   id_rs1_i;
    logic [REG_AW-1:0]   id_rs2_i;
    logic [REG_AW-1:0]   id_rd_i;
    logic                id_uses_rs1_i;
    logic                id_uses_rs2_i;
    logic [CTRL_W-1:0]   id_ctrl_i;
    logic                exe_branch_taken_i;

    logic                pc_write_o;
    logic                ifid_write_o;
    logic                ifid_flush_o;
    logic                exe_valid_o;
    logic [DATA_W-1:0]   exe_pc_o;
    logic [DATA_W-1:0]   exe_rs1_data_o;
    logic [DATA_W-1:0]   exe_rs2_data_o;
    logic [DATA_W-1:0]   exe_imm_o;
    logic [REG_AW-1:0]   exe_rs1_o;
    logic [REG_AW-1:0]   exe_rs2_o;
    logic [REG_AW-1:0]   exe_rd_o;
    logic [CTRL_W-1:0]   exe_ctrl_o;
    logic [31:0]         stall_cnt_o;
    logic [31:0]         flush_cnt_o;

    modport master (
        output hold_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, id_ctrl_i,
               exe_branch_taken_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, exe_valid_o, exe_pc_o,
               exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_rs1_o, exe_rs2_o,
               exe_rd_o, exe_ctrl_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  hold_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_uses_rs1_i, id_uses_rs2_i, id_ctrl_i,
               exe_branch_taken_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, exe_valid_o, exe_pc_o,
               exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_rs1_o, exe_rs2_o,
               exe_rd_o, exe_ctrl_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_idexe_stage_hazard_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              exe_valid,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] exe_rd,
    output logic              hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == exe_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == exe_rd);
    assign hazard  = id_valid && exe_valid && exe_mem_read && (exe_rd != '0)
                     && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_idexe_stage.sv
// ID/EX pipeline register with load-use stall, taken-branch flush, global hold
// and saturating stall/flush event counters.
module hazard_idexe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_idexe_stage_if.slave  bus
);
    import pipe_pkg::*;

    logic              hazard;
    action_e           action;

    logic              exe_valid;
    logic [DATA_W-1:0] exe_pc;
    logic [DATA_W-1:0] exe_rs1_data;
    logic [DATA_W-1:0] exe_rs2_data;
    logic [DATA_W-1:0] exe_imm;
    logic [REG_AW-1:0] exe_rs1;
    logic [REG_AW-1:0] exe_rs2;
    logic [REG_AW-1:0] exe_rd;
    logic [CTRL_W-1:0] exe_ctrl;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .id_valid     (bus.id_valid_i),
        .id_rs1       (bus.id_rs1_i),
        .id_rs2       (bus.id_rs2_i),
        .id_uses_rs1  (bus.id_uses_rs1_i),
        .id_uses_rs2  (bus.id_uses_rs2_i),
        .exe_valid    (exe_valid),
        .exe_mem_read (exe_ctrl[CTRL_MEM_READ]),
        .exe_rd       (exe_rd),
        .hazard       (hazard)
    );

    // Hold outranks a taken branch so the branch stays in EX until released.
    always_comb begin
        action = ACT_PASS;
        if (bus.hold_i)                  action = ACT_HOLD;
        else if (bus.exe_branch_taken_i) action = ACT_FLUSH;
        else if (hazard)                 action = ACT_STALL;
    end

    assign bus.pc_write_o   = (action == ACT_PASS) || (action == ACT_FLUSH);
    assign bus.ifid_write_o = (action == ACT_PASS) || (action == ACT_FLUSH);
    assign bus.ifid_flush_o = (action == ACT_FLUSH);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exe_valid    <= 1'b0;
            exe_pc       <= '0;
            exe_rs1_data <= '0;
            exe_rs2_data <= '0;
            exe_imm      <= '0;
            exe_rs1      <= '0;
            exe_rs2      <= '0;
            exe_rd       <= '0;
            exe_ctrl     <= CTRL_BUBBLE;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            unique case (action)
                ACT_HOLD: ;
                ACT_FLUSH, ACT_STALL: begin
                    exe_valid    <= 1'b0;
                    exe_pc       <= '0;
                    exe_rs1_data <= '0;
                    exe_rs2_data <= '0;
                    exe_imm      <= '0;
                    exe_rs1      <= '0;
                    exe_rs2      <= '0;
                    exe_rd       <= '0;
                    exe_ctrl     <= CTRL_BUBBLE;
                end
                default: begin
                    exe_valid    <= bus.id_valid_i;
                    exe_pc       <= bus.id_pc_i;
                    exe_rs1_data <= bus.id_rs1_data_i;
                    exe_rs2_data <= bus.id_rs2_data_i;
                    exe_imm      <= bus.id_imm_i;
                    exe_rs1      <= bus.id_rs1_i;
                    exe_rs2      <= bus.id_rs2_i;
                    exe_rd       <= bus.id_rd_i;
                    exe_ctrl     <= bus.id_valid_i ? bus.id_ctrl_i : CTRL_BUBBLE;
                end
            endcase
            if (action == ACT_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (action == ACT_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.exe_valid_o    = exe_valid;
    assign bus.exe_pc_o       = exe_pc;
    assign bus.exe_rs1_data_o = exe_rs1_data;
    assign bus.exe_rs2_data_o = exe_rs2_data;
    assign bus.exe_imm_o      = exe_imm;
    assign bus.exe_rs1_o      = exe_rs1;
    assign bus.exe_rs2_o      = exe_rs2;
    assign bus.exe_rd_o       = exe_rd;
    assign bus.exe_ctrl_o     = exe_ctrl;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_idexe_stage.sv
// Directed bench for the ID/EX stage: load-use stall, x0/no-use cases, branch
// flush, hold, invalid ID, counter saturation and asynchronous reset.
module tb_hazard_idexe_stage;

    localparam logic [7:0] LW  = 8'hE4;
    localparam logic [7:0] ADD = 8'h82;
    localparam logic [7:0] LUI = 8'h84;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;

    hazard_idexe_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    hazard_idexe_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [7:0] ctrl);
        bus.id_valid_i    = v;
        bus.id_pc_i       = pc;
        bus.id_rs1_data_i = 32'h1000_0000 | 32'(rs1);
        bus.id_rs2_data_i = 32'h2000_0000 | 32'(rs2);
        bus.id_imm_i      = pc + 32'h0000_1000;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_uses_rs1_i = u1;
        bus.id_uses_rs2_i = u2;
        bus.id_ctrl_i     = ctrl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.hold_i = 1'b0;
        bus.exe_branch_taken_i = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00);
        #12;
        total++; if (bus.exe_valid_o !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", bus.exe_valid_o); else passed++;
        total++; if (bus.exe_ctrl_o !== 8'h00) $display("FAIL reset_ctrl got=%0h exp=0", bus.exe_ctrl_o); else passed++;
        total++; if (bus.stall_cnt_o !== 32'd0) $display("FAIL reset_stall_cnt got=%0h exp=0", bus.stall_cnt_o); else passed++;
        total++; if (bus.flush_cnt_o !== 32'd0) $display("FAIL reset_flush_cnt got=%0h exp=0", bus.flush_cnt_o); else passed++;
        total++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1 || bus.ifid_flush_o !== 1'b0)
            $display("FAIL reset_comb got pc=%0b ifid_w=%0b flush=%0b exp 1/1/0",
                     bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 32'h40, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'h44, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, ADD);
        #1;
        total++; if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0 || bus.ifid_flush_o !== 1'b0)
            $display("FAIL lu_stall_comb got pc=%0b ifid_w=%0b flush=%0b exp 0/0/0",
                     bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o);
        else passed++;
        tick();
        exp_stall = 32'd1;
        total++; if (bus.exe_valid_o !== 1'b0 || bus.exe_ctrl_o !== 8'h00)
            $display("FAIL lu_bubble got valid=%0b ctrl=%0h exp 0/00", bus.exe_valid_o, bus.exe_ctrl_o);
        else passed++;
        total++; if (bus.stall_cnt_o !== exp_stall) $display("FAIL lu_stall_cnt got=%0h exp=%0h", bus.stall_cnt_o, exp_stall); else passed++;
        total++; if (bus.pc_write_o !== 1'b1) $display("FAIL lu_release got=%0b exp=1", bus.pc_write_o); else passed++;
        tick();
        total++; if (bus.exe_valid_o !== 1'b1 || bus.exe_ctrl_o !== ADD || bus.exe_rd_o !== 5'd6 ||
                     bus.exe_rs1_o !== 5'd5 || bus.exe_rs2_o !== 5'd7 || bus.exe_pc_o !== 32'h44 ||
                     bus.exe_imm_o !== 32'h1044 || bus.exe_rs1_data_o !== 32'h1000_0005 ||
                     bus.exe_rs2_data_o !== 32'h2000_0007)
            $display("FAIL lu_add_enters got v=%0b ctrl=%0h rd=%0d rs1=%0d rs2=%0d pc=%0h imm=%0h d1=%0h d2=%0h exp 1/82/6/5/7/44/1044/10000005/20000007",
                     bus.exe_valid_o, bus.exe_ctrl_o, bus.exe_rd_o, bus.exe_rs1_o, bus.exe_rs2_o,
                     bus.exe_pc_o, bus.exe_imm_o, bus.exe_rs1_data_o, bus.exe_rs2_data_o);
        else passed++;
    endtask

    task automatic test_no_stall();
        set_id(1'b1, 32'h50, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'h54, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, ADD);
        #1;
        total++; if (bus.pc_write_o !== 1'b1) $display("FAIL x0_no_stall got=%0b exp=1", bus.pc_write_o); else passed++;
        tick();
        set_id(1'b1, 32'h58, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'h5c, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, LUI);
        #1;
        total++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1)
            $display("FAIL nouse_no_stall got pc=%0b ifid_w=%0b exp 1/1", bus.pc_write_o, bus.ifid_write_o);
        else passed++;
        tick();
        total++; if (bus.exe_ctrl_o !== LUI || bus.exe_rd_o !== 5'd5 || bus.stall_cnt_o !== exp_stall)
            $display("FAIL nouse_enters got ctrl=%0h rd=%0d stall=%0h exp 84/5/%0h",
                     bus.exe_ctrl_o, bus.exe_rd_o, bus.stall_cnt_o, exp_stall);
        else passed++;
    endtask

    task automatic test_branch();
        set_id(1'b1, 32'h60, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'h64, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, ADD);
        bus.exe_branch_taken_i = 1'b1;
        #1;
        total++; if (bus.ifid_flush_o !== 1'b1 || bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1)
            $display("FAIL br_comb got flush=%0b pc=%0b ifid_w=%0b exp 1/1/1",
                     bus.ifid_flush_o, bus.pc_write_o, bus.ifid_write_o);
        else passed++;
        tick();
        bus.exe_branch_taken_i = 1'b0;
        exp_flush = 32'd1;
        total++; if (bus.exe_valid_o !== 1'b0 || bus.exe_ctrl_o !== 8'h00 || bus.exe_rd_o !== 5'd0 || bus.exe_pc_o !== 32'h0)
            $display("FAIL br_bubble got v=%0b ctrl=%0h rd=%0d pc=%0h exp 0/00/0/0",
                     bus.exe_valid_o, bus.exe_ctrl_o, bus.exe_rd_o, bus.exe_pc_o);
        else passed++;
        total++; if (bus.flush_cnt_o !== exp_flush || bus.stall_cnt_o !== exp_stall)
            $display("FAIL br_counters got flush=%0h stall=%0h exp %0h/%0h",
                     bus.flush_cnt_o, bus.stall_cnt_o, exp_flush, exp_stall);
        else passed++;
    endtask

    task automatic test_invalid_id();
        set_id(1'b0, 32'h70, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1, ADD);
        tick();
        total++; if (bus.exe_valid_o !== 1'b0 || bus.exe_ctrl_o !== 8'h00 || bus.exe_rd_o !== 5'd3 || bus.exe_pc_o !== 32'h70)
            $display("FAIL invalid_id got v=%0b ctrl=%0h rd=%0d pc=%0h exp 0/00/3/70",
                     bus.exe_valid_o, bus.exe_ctrl_o, bus.exe_rd_o, bus.exe_pc_o);
        else passed++;
    endtask

    task automatic test_hold();
        set_id(1'b1, 32'h80, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, ADD);
        tick();
        set_id(1'b1, 32'h84, 5'd1, 5'd1, 5'd8, 1'b1, 1'b1, LW);
        bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.exe_branch_taken_i = (i == 2);
            #1;
            total++; if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0 || bus.ifid_flush_o !== 1'b0)
                $display("FAIL hold_comb[%0d] got pc=%0b ifid_w=%0b flush=%0b exp 0/0/0",
                         i, bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o);
            else passed++;
            tick();
            total++; if (bus.exe_valid_o !== 1'b1 || bus.exe_pc_o !== 32'h80 || bus.exe_rd_o !== 5'd1 ||
                         bus.exe_ctrl_o !== ADD || bus.stall_cnt_o !== exp_stall || bus.flush_cnt_o !== exp_flush)
                $display("FAIL hold_keep[%0d] got v=%0b pc=%0h rd=%0d ctrl=%0h st=%0h fl=%0h exp 1/80/1/82/%0h/%0h",
                         i, bus.exe_valid_o, bus.exe_pc_o, bus.exe_rd_o, bus.exe_ctrl_o,
                         bus.stall_cnt_o, bus.flush_cnt_o, exp_stall, exp_flush);
            else passed++;
        end
        bus.hold_i = 1'b0;
        #1;
        total++; if (bus.ifid_flush_o !== 1'b1) $display("FAIL hold_branch_after got=%0b exp=1", bus.ifid_flush_o); else passed++;
        tick();
        bus.exe_branch_taken_i = 1'b0;
        exp_flush = 32'd2;
        total++; if (bus.flush_cnt_o !== exp_flush || bus.exe_valid_o !== 1'b0)
            $display("FAIL hold_branch_flush got fl=%0h v=%0b exp %0h/0", bus.flush_cnt_o, bus.exe_valid_o, exp_flush);
        else passed++;
    endtask

    task automatic test_saturate();
        set_id(1'b1, 32'h90, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        set_id(1'b1, 32'h94, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ADD);
        #1;
        total++; if (bus.stall_cnt_o !== 32'hFFFF_FFFE) $display("FAIL sat_preload got=%0h exp=fffffffe", bus.stall_cnt_o); else passed++;
        tick();
        total++; if (bus.stall_cnt_o !== 32'hFFFF_FFFF) $display("FAIL sat_reach got=%0h exp=ffffffff", bus.stall_cnt_o); else passed++;
        set_id(1'b1, 32'h98, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'h9c, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, ADD);
        #1;
        total++; if (bus.pc_write_o !== 1'b0) $display("FAIL sat_rs2_hazard got=%0b exp=0", bus.pc_write_o); else passed++;
        tick();
        total++; if (bus.stall_cnt_o !== 32'hFFFF_FFFF) $display("FAIL sat_hold got=%0h exp=ffffffff", bus.stall_cnt_o); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 32'hA0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, LW);
        tick();
        set_id(1'b1, 32'hA4, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, ADD);
        #1;
        total++; if (bus.pc_write_o !== 1'b0) $display("FAIL rst_pre_stall got=%0b exp=0", bus.pc_write_o); else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.exe_valid_o !== 1'b0 || bus.exe_ctrl_o !== 8'h00 || bus.stall_cnt_o !== 32'd0 ||
                     bus.flush_cnt_o !== 32'd0 || bus.pc_write_o !== 1'b1)
            $display("FAIL rst_async got v=%0b ctrl=%0h st=%0h fl=%0h pc=%0b exp 0/00/0/0/1",
                     bus.exe_valid_o, bus.exe_ctrl_o, bus.stall_cnt_o, bus.flush_cnt_o, bus.pc_write_o);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.exe_valid_o !== 1'b1 || bus.exe_rd_o !== 5'd6 || bus.stall_cnt_o !== 32'd0)
            $display("FAIL rst_restart got v=%0b rd=%0d st=%0h exp 1/6/0",
                     bus.exe_valid_o, bus.exe_rd_o, bus.stall_cnt_o);
        else passed++;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_invalid_id();
        test_hold();
        test_saturate();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
